// File: rtl/grey_sync_pkg.sv
// Shared types and helpers for the grey-vector synchronizer/decoder.
// The helpers work on a wide zero-extended vector so any width up to GREY_MAX_W can use them.
package grey_sync_pkg;

  localparam int unsigned GREY_MAX_W = 64;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } sync_state_t;

  // Zero upper bits do not disturb the prefix-XOR, so narrower vectors decode correctly.
  function automatic logic [GREY_MAX_W-1:0] grey2bin(input logic [GREY_MAX_W-1:0] g);
    logic [GREY_MAX_W-1:0] b;
    b[GREY_MAX_W-1] = g[GREY_MAX_W-1];
    for (int i = GREY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GREY_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GREY_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/greyvector_sync_dec_if.sv
// Bundle of the source-side input and the clk_dest-side results of greyvector_sync_dec.
// master drives the grey vector and error clear; slave is the decoder.
interface greyvector_sync_dec_if #(
  parameter int VECTORWIDTH = 4,
  parameter int ERRCNT_W    = 4
);

  logic [VECTORWIDTH-1:0] vect_src;
  logic                   clr_err;
  logic                   valid_dest;
  logic [VECTORWIDTH-1:0] grey_dest;
  logic [VECTORWIDTH-1:0] bin_dest;
  logic [VECTORWIDTH-1:0] delta_dest;
  logic                   adv_dest;
  logic                   err_dest;
  logic                   err_sticky;
  logic [ERRCNT_W-1:0]    err_cnt;

  modport master (
    output vect_src,
    output clr_err,
    input  valid_dest,
    input  grey_dest,
    input  bin_dest,
    input  delta_dest,
    input  adv_dest,
    input  err_dest,
    input  err_sticky,
    input  err_cnt
  );

  modport slave (
    input  vect_src,
    input  clr_err,
    output valid_dest,
    output grey_dest,
    output bin_dest,
    output delta_dest,
    output adv_dest,
    output err_dest,
    output err_sticky,
    output err_cnt
  );

endinterface

// File: rtl/grey_sync_chain.sv
// Plain multi-flop synchronizer for a grey vector: no logic between stages, all stages reset to 0.
module grey_sync_chain #(
  parameter int VECTORWIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_dest,
  input  logic                   rst_dest_n,
  input  logic [VECTORWIDTH-1:0] vect_src,
  output logic [VECTORWIDTH-1:0] gsync
);

  genvar gi;
  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    logic [VECTORWIDTH-1:0] stage_reg;
    if (gi == 0) begin : g_first
      // First stage samples the asynchronous source directly.
      always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= vect_src;
        end
      end
    end else begin : g_follow
      always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  end

  assign gsync = g_stage[SYNC_STAGES-1].stage_reg;

endmodule

// File: rtl/greyvector_sync_dec.sv
// Grey-vector synchronizer into clk_dest with binary decode, modular advance reporting and
// multi-bit transition detection; a start-up FSM keeps reports quiet while the chain fills.
module greyvector_sync_dec
  import grey_sync_pkg::*;
#(
  parameter int VECTORWIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CHK     = 1,
  parameter int ERRCNT_W    = 4
) (
  input  logic                clk_dest,
  input  logic                rst_dest_n,
  greyvector_sync_dec_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("greyvector_sync_dec: SYNC_STAGES must be at least 2");
  end
  if (VECTORWIDTH < 2 || VECTORWIDTH > int'(GREY_MAX_W)) begin : g_bad_width
    $error("greyvector_sync_dec: VECTORWIDTH out of range");
  end

  localparam int CNT_W = $clog2(SYNC_STAGES);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SYNC_STAGES - 1);

  logic [VECTORWIDTH-1:0] gsync;
  logic [VECTORWIDTH-1:0] gsync_bin;

  sync_state_t            state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   valid_reg, valid_next;
  logic [VECTORWIDTH-1:0] grey_reg, grey_next;
  logic [VECTORWIDTH-1:0] bin_reg, bin_next;
  logic [VECTORWIDTH-1:0] delta_reg, delta_next;
  logic                   adv_reg, adv_next;
  logic                   err_reg, err_next;
  logic                   sticky_reg;
  logic [ERRCNT_W-1:0]    errcnt_reg;

  grey_sync_chain #(
    .VECTORWIDTH (VECTORWIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chain (
    .clk_dest   (clk_dest),
    .rst_dest_n (rst_dest_n),
    .vect_src   (bus.vect_src),
    .gsync      (gsync)
  );

  assign gsync_bin = VECTORWIDTH'(grey2bin(GREY_MAX_W'(gsync)));

  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      grey_reg  <= '0;
      bin_reg   <= '0;
      delta_reg <= '0;
      adv_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      grey_reg  <= grey_next;
      bin_reg   <= bin_next;
      delta_reg <= delta_next;
      adv_reg   <= adv_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    grey_next  = grey_reg;
    bin_next   = bin_reg;
    delta_next = '0;
    adv_next   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      FILL: begin
        // Chain contents are not yet a real source sample; keep everything at 0.
        cnt_next   = cnt_reg + 1'b1;
        valid_next = 1'b0;
        grey_next  = '0;
        bin_next   = '0;
        if (cnt_reg == FILL_LAST) begin
          state_next = SEED;
        end
      end
      SEED: begin
        // Baseline sample: no previous value to compare against.
        grey_next  = gsync;
        bin_next   = gsync_bin;
        valid_next = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        grey_next  = gsync;
        bin_next   = gsync_bin;
        delta_next = gsync_bin - bin_reg;
        adv_next   = (gsync != grey_reg);
        if (ERR_CHK != 0) begin
          err_next = (popcount(GREY_MAX_W'(gsync ^ grey_reg)) > 32'd1);
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  if (ERR_CHK != 0) begin : g_err_track
    // A fresh error in the same cycle as a clear takes precedence over the clear.
    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
      if (!rst_dest_n) begin
        sticky_reg <= 1'b0;
        errcnt_reg <= '0;
      end else if (err_next) begin
        sticky_reg <= 1'b1;
        if (bus.clr_err) begin
          errcnt_reg <= ERRCNT_W'(1);
        end else if (errcnt_reg != '1) begin
          errcnt_reg <= errcnt_reg + 1'b1;
        end
      end else if (bus.clr_err) begin
        sticky_reg <= 1'b0;
        errcnt_reg <= '0;
      end
    end
  end else begin : g_no_err_track
    assign sticky_reg = 1'b0;
    assign errcnt_reg = '0;
  end

  assign bus.valid_dest = valid_reg;
  assign bus.grey_dest  = grey_reg;
  assign bus.bin_dest   = bin_reg;
  assign bus.delta_dest = delta_reg;
  assign bus.adv_dest   = adv_reg;
  assign bus.err_dest   = err_reg;
  assign bus.err_sticky = sticky_reg;
  assign bus.err_cnt    = errcnt_reg;

endmodule

// File: tb/tb_greyvector_sync_dec.sv
// Bench for greyvector_sync_dec: four configurations share one grey stimulus stream; the
// default instance's advance pulses are checked against a scoreboard of expected samples.
module tb_greyvector_sync_dec;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] delta;
    logic       err;
  } exp_t;

  logic       clk_dest = 1'b0;
  logic       rst_dest_n = 1'b0;
  logic [3:0] vect = 4'b0110;
  logic       clr = 1'b0;
  logic [3:0] cur_bin = 4'd4;

  int total = 0;
  int bad = 0;
  exp_t sb_q[$];

  always #5 clk_dest = ~clk_dest;

  // a: defaults, b: no error check, c: 2-bit error counter, d: 4 sync stages
  greyvector_sync_dec_if #(.VECTORWIDTH(4), .ERRCNT_W(4)) bus_a ();
  greyvector_sync_dec_if #(.VECTORWIDTH(4), .ERRCNT_W(4)) bus_b ();
  greyvector_sync_dec_if #(.VECTORWIDTH(4), .ERRCNT_W(2)) bus_c ();
  greyvector_sync_dec_if #(.VECTORWIDTH(4), .ERRCNT_W(4)) bus_d ();

  assign bus_a.vect_src = vect;
  assign bus_b.vect_src = vect;
  assign bus_c.vect_src = vect;
  assign bus_d.vect_src = vect;
  assign bus_a.clr_err  = clr;
  assign bus_b.clr_err  = clr;
  assign bus_c.clr_err  = clr;
  assign bus_d.clr_err  = clr;

  greyvector_sync_dec #(.VECTORWIDTH(4), .SYNC_STAGES(2), .ERR_CHK(1), .ERRCNT_W(4)) dut_a (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .bus(bus_a));
  greyvector_sync_dec #(.VECTORWIDTH(4), .SYNC_STAGES(2), .ERR_CHK(0), .ERRCNT_W(4)) dut_b (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .bus(bus_b));
  greyvector_sync_dec #(.VECTORWIDTH(4), .SYNC_STAGES(2), .ERR_CHK(1), .ERRCNT_W(2)) dut_c (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .bus(bus_c));
  greyvector_sync_dec #(.VECTORWIDTH(4), .SYNC_STAGES(4), .ERR_CHK(1), .ERRCNT_W(4)) dut_d (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .bus(bus_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_dest);
    #1;
  endtask

  // Drive the grey code of b and record what instance a should report for it.
  task automatic drive_bin(input logic [3:0] b, input int hold);
    logic [3:0] g;
    exp_t e;
    g = b ^ (b >> 1);
    e.bin   = b;
    e.delta = b - cur_bin;
    e.err   = ($countones(g ^ vect) > 1);
    sb_q.push_back(e);
    cur_bin = b;
    vect    = g;
    repeat (hold) step();
  endtask

  initial begin : sb_monitor
    exp_t e;
    forever begin
      @(posedge clk_dest);
      #1;
      if (bus_a.adv_dest || bus_a.err_dest) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'({bus_a.adv_dest, bus_a.err_dest}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("sb: bin=%0d delta=%0d err=%0b (want %0d %0d %0b)",
                   bus_a.bin_dest, bus_a.delta_dest, bus_a.err_dest, e.bin, e.delta, e.err);
          chk("sb_adv", 32'(bus_a.adv_dest), 32'd1);
          chk("sb_bin", 32'(bus_a.bin_dest), 32'(e.bin));
          chk("sb_delta", 32'(bus_a.delta_dest), 32'(e.delta));
          chk("sb_err", 32'(bus_a.err_dest), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset state with the source already holding 0110.
    repeat (3) step();
    chk("rst_a_outs", 32'({bus_a.valid_dest, bus_a.grey_dest, bus_a.bin_dest, bus_a.delta_dest,
        bus_a.adv_dest, bus_a.err_dest, bus_a.err_sticky, bus_a.err_cnt}), 32'd0);
    rst_dest_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("fill_a_valid_e%0d", e), 32'(bus_a.valid_dest), 32'(e >= 3));
      chk($sformatf("fill_d_valid_e%0d", e), 32'(bus_d.valid_dest), 32'(e >= 5));
      if (e == 3) begin
        chk("seed_a_grey", 32'(bus_a.grey_dest), 32'h6);
        chk("seed_a_bin", 32'(bus_a.bin_dest), 32'd4);
        chk("seed_a_pulses", 32'({bus_a.adv_dest, bus_a.err_dest, bus_a.delta_dest}), 32'd0);
      end
    end
    chk("seed_d_grey", 32'(bus_d.grey_dest), 32'h6);

    // Legal count up through 15 and the wrap to 0.
    for (int b = 5; b <= 15; b++) drive_bin(4'(b), 3);
    drive_bin(4'd0, 6);
    chk("count_a_sticky", 32'(bus_a.err_sticky), 32'd0);

    // Single step seen through the 4-stage instance.
    drive_bin(4'd1, 0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("d_grey_e%0d", e), 32'(bus_d.grey_dest), 32'(e >= 5));
      chk($sformatf("d_adv_e%0d", e), 32'(bus_d.adv_dest), 32'(e == 5));
    end

    for (int b = 2; b <= 8; b++) drive_bin(4'(b), 3);
    drive_bin(4'd9, 6);
    chk("pre_rst_a_bin", 32'(bus_a.bin_dest), 32'd9);

    // Asynchronous reset in the middle of a cycle, source held at grey(9).
    #3;
    rst_dest_n = 1'b0;
    #1;
    chk("midrst_a_outs", 32'({bus_a.valid_dest, bus_a.grey_dest, bus_a.bin_dest, bus_a.delta_dest,
        bus_a.adv_dest, bus_a.err_dest, bus_a.err_sticky, bus_a.err_cnt}), 32'd0);
    chk("midrst_d_outs", 32'({bus_d.valid_dest, bus_d.grey_dest, bus_d.bin_dest}), 32'd0);
    step();
    rst_dest_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("rerun_a_valid_e%0d", e), 32'(bus_a.valid_dest), 32'(e >= 3));
      if (e >= 3) begin
        chk($sformatf("rerun_a_bin_e%0d", e), 32'(bus_a.bin_dest), 32'd9);
        chk($sformatf("rerun_a_grey_e%0d", e), 32'(bus_a.grey_dest), 32'hD);
        chk($sformatf("rerun_a_pulses_e%0d", e), 32'({bus_a.adv_dest, bus_a.err_dest}), 32'd0);
      end
    end

    for (int b = 10; b <= 15; b++) drive_bin(4'(b), 3);
    drive_bin(4'd0, 3);
    chk("clean_a_errs", 32'({bus_a.err_sticky, bus_a.err_cnt}), 32'd0);
    chk("clean_c_errs", 32'({bus_c.err_sticky, bus_c.err_cnt}), 32'd0);

    // Illegal jump 0000 -> 0011 (binary 2).
    drive_bin(4'd2, 3);
    chk("jump1_a_sticky", 32'(bus_a.err_sticky), 32'd1);
    chk("jump1_a_cnt", 32'(bus_a.err_cnt), 32'd1);
    chk("jump1_b_adv", 32'(bus_b.adv_dest), 32'd1);
    chk("jump1_b_delta", 32'(bus_b.delta_dest), 32'd2);
    chk("jump1_b_bin", 32'(bus_b.bin_dest), 32'd2);
    chk("jump1_b_errs", 32'({bus_b.err_dest, bus_b.err_sticky, bus_b.err_cnt}), 32'd0);

    drive_bin(4'd0, 3);
    drive_bin(4'd2, 3);
    drive_bin(4'd0, 3);
    drive_bin(4'd2, 3);
    chk("jump5_a_cnt", 32'(bus_a.err_cnt), 32'd5);
    chk("jump5_c_cnt_sat", 32'(bus_c.err_cnt), 32'd3);
    chk("jump5_c_sticky", 32'(bus_c.err_sticky), 32'd1);
    chk("jump5_b_errs", 32'({bus_b.err_sticky, bus_b.err_cnt}), 32'd0);

    // Clear alone.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_a_errs", 32'({bus_a.err_sticky, bus_a.err_cnt}), 32'd0);
    chk("clr_c_errs", 32'({bus_c.err_sticky, bus_c.err_cnt}), 32'd0);

    // Clear landing on the same edge as a new error.
    drive_bin(4'd0, 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clrerr_a_err", 32'(bus_a.err_dest), 32'd1);
    chk("clrerr_a_errs", 32'({bus_a.err_sticky, bus_a.err_cnt}), 32'h11);
    chk("clrerr_c_errs", 32'({bus_c.err_sticky, bus_c.err_cnt}), 32'h5);

    repeat (4) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/greyvector_sync_dec.md
Name: greyvector_sync_dec

Overview:
- Parametrised grey-vector synchronizer for moving grey-coded counters and pointers (e.g. FIFO pointers) from a source domain into clk_dest.
- Configurable synchronizer depth.
- After synchronizing, the block:
  - decodes the value to binary;
  - reports the modular advance since the previous sample;
  - flags illegal multi-bit grey transitions, with a sticky flag and a saturating counter.
- A start-up FSM suppresses false advance/error reports while the chain fills after reset.

Parameters:
- VECTORWIDTH, 4: width of grey vector, ≥2.
- SYNC_STAGES, 2: synchronizer flops, ≥2. Elaboration error if <2.
- ERR_CHK, 1: 1 enables the multi-bit transition check; 0 forces err_* outputs to 0.
- ERRCNT_W, 4: width of error counter.

Ports:
- clk_dest  in  1  destination clock.
- rst_dest_n  in  1  reset, asynchronous, active-low.
- vect_src  in  VECTORWIDTH  grey vector from the source domain. Must be driven directly from source flops.
- clr_err  in  1  synchronous clear of err_sticky and err_cnt (clk_dest domain).
- valid_dest  out  1  high once the baseline sample is loaded.
- grey_dest  out  VECTORWIDTH  synchronized grey value.
- bin_dest  out  VECTORWIDTH  binary decode of grey_dest.
- delta_dest  out  VECTORWIDTH  bin_new − bin_prev, mod 2^VECTORWIDTH.
- adv_dest  out  1  one-cycle pulse, delta_dest≠0.
- err_dest  out  1  one-cycle pulse, illegal transition sampled.
- err_sticky  out  1  sticky error flag.
- err_cnt  out  ERRCNT_W  saturating count of illegal transitions.

Behaviour:
Reset:
- All flops, including the sync chain, go to 0 asynchronously.
- All outputs are 0; FSM enters FILL.

Sync chain and pipeline:
- SYNC_STAGES flops form the chain; gsync is the last stage.
- No logic between chain stages.
- A source value stable before clk edge k appears on grey_dest/bin_dest/delta_dest/adv_dest after edge k+SYNC_STAGES. Latency is SYNC_STAGES+1 edges.

FSM:
- FILL:
  - A counter increments each edge.
  - At the edge where count reaches SYNC_STAGES−1, go to SEED.
  - Outputs are held at 0.
- SEED (1 cycle):
  - grey_dest←gsync, bin_dest←g2b(gsync), valid_dest←1.
  - delta_dest=0, adv_dest=0, err_dest=0.
  - Go to RUN.
- RUN (terminal until reset). Each edge:
  - grey_dest←gsync.
  - bin_dest←g2b(gsync).
  - delta_dest←g2b(gsync)−bin_dest, modular, with no carry output.
  - adv_dest←(gsync≠grey_dest).
  - err_dest←ERR_CHK && popcount(gsync^grey_dest)>1.
- An error still updates grey/bin/delta to the sampled value; there is no hold and no correction.

Grey decode:
- b[MSB]=g[MSB].
- b[i]=b[i+1]^g[i].

Wrap:
- Grey 10..0 → 00..0 decodes as max→0, giving delta=1. This is a legal transition.

Error counter:
- err_cnt increments on err_dest and saturates at 2^ERRCNT_W−1.
- err_sticky sets on err_dest.
- clr_err alone: err_sticky←0, err_cnt←0.
- clr_err together with a new error in the same cycle: err_sticky←1, err_cnt←1 (the new error wins over the clear).
- clr_err in FILL/SEED: clears as normal.

Reset mid-operation:
- Immediate return to FILL with all outputs 0.
- No advance or error is reported for the first post-reset sample.

Source-rate constraint:
- ERR_CHK=1 requires at most one grey step per clk_dest period.
- Faster sources must use ERR_CHK=0; delta_dest still reports multi-step advances correctly.

Decomposition:
Package grey_sync_pkg contains:
- typedef enum {FILL, SEED, RUN} for the FSM state;
- function grey2bin (parametrised width);
- function popcount.

One sub-module, grey_sync_chain (params VECTORWIDTH, SYNC_STAGES):
- pure reset-to-0 flop chain, no logic.
- Top level instantiates the chain and holds the FSM, decode, delta and error logic.

Test Plan:
(VECTORWIDTH=4, SYNC_STAGES=2 unless noted)
1. Reset release with vect_src=4'b0110 held:
   - valid_dest=0 after edges 1–2.
   - After edge 3: valid_dest=1, grey_dest=0110, bin_dest=4, adv_dest=0, err_dest=0.
2. Grey count 0→15→0, one step every 3 clk_dest:
   - Each step gives one adv_dest pulse with delta_dest=1.
   - bin_dest follows 0..15, then wraps to 0 with delta_dest=1.
   - err_sticky stays 0.
3. Illegal jump 0000→0011:
   - err_dest pulse, err_sticky=1, err_cnt=1.
   - bin_dest=2, delta_dest=2, adv_dest=1.
   - Repeat with ERR_CHK=0: no error outputs, delta_dest=2.
4. ERRCNT_W=2 with 5 illegal jumps:
   - err_cnt=3 (saturated).
   - clr_err pulse → err_cnt=0, err_sticky=0.
   - clr_err in the same cycle as a new error → err_sticky=1, err_cnt=1.
5. In RUN with bin_dest=9, assert rst_dest_n low mid-cycle:
   - All outputs 0 immediately.
   - After release with vect_src holding grey(9)=1101: valid_dest=1 after edge 3, bin_dest=9, no adv or err pulse.
6. SYNC_STAGES=4, single source step 0000→0001:
   - grey_dest changes exactly 5 edges after the step.
   - adv_dest pulses for one cycle; valid_dest rises after edge 5 post-reset.
